seg_p2s: RTL
============

Name: seg_p2s

Overview:
Parallel-to-serial driver for the board's 8-digit 7-segment display. It sits directly downstream of the hex-to-segment encoder and consumes its 64-bit segment word (8 digits x {a,b,c,d,e,f,g,p}). It shifts that word out on a divided serial clock into the on-board shift-register chain, then pulses the latch. A start/busy/done handshake decouples it from the producing logic.

Parameters:
DATA_W, 64, width of segment word shifted per frame (8 digits x 8 bits)
HALF_DIV, 2, system clocks per half period of ser_clk; legal range 1..255
MSB_FIRST, 1, 1 = seg_txt[DATA_W-1] shifted first; 0 = seg_txt[0] first

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
seg_txt  in  DATA_W  segment word from encoder; sampled only on accepted start
start  in  1  request a frame; accepted only in IDLE
busy  out  1  high from cycle after acceptance until done cycle (exclusive)
done  out  1  one-cycle pulse when frame and latch are complete
ser_clk  out  1  serial shift clock to shift-register chain
ser_dat  out  1  serial data, stable across each ser_clk rising edge
ser_latch  out  1  storage-register latch pulse, high after last bit
ser_clr_n  out  1  shift-chain clear, active-low

Behaviour:
- All outputs registered. Reset values: busy=0, done=0, ser_clk=0, ser_dat=0, ser_latch=0, ser_clr_n=0. ser_clr_n goes to 1 in the first cycle after rst deasserts and stays 1.
- States: IDLE, SHIFT, LATCH.
- IDLE: start=1 -> capture seg_txt into shift register, bit counter=0, phase counter=0 -> SHIFT. This is cycle 0. Start in any other state is ignored, not queued.
- SHIFT: busy=1. ser_dat = current head bit (MSB or LSB per MSB_FIRST), valid from the first cycle of each bit.
  - Each bit has a low phase (ser_clk=0, HALF_DIV cycles) then a high phase (ser_clk=1, HALF_DIV cycles).
  - At the end of the high phase the shift register advances and the bit counter increments.
  - After bit DATA_W-1 completes: ser_clk=0 -> LATCH.
  - ser_dat never changes in a cycle where ser_clk rises.
- LATCH: ser_latch=1 for HALF_DIV cycles. Next cycle: ser_latch=0, busy=0, done=1 for one cycle, state IDLE.
- Latency with start accepted in cycle 0:
  - busy rises in cycle 1.
  - ser_clk rising edges occur in cycles 1+H+2H*k, for k=0..DATA_W-1 (H=HALF_DIV).
  - ser_latch is high in cycles 2H*DATA_W+1 .. 2H*DATA_W+H.
  - done occurs in cycle 2H*DATA_W+H+1. Defaults: done in cycle 259.
- A start in the same cycle as done is accepted (state is IDLE). busy stays 0 that cycle and rises next cycle.
- seg_txt changes during a frame do not affect the frame in flight.
- Bit and phase counters wrap only by explicit reload; no overflow paths.
- Reset mid-frame: abort on the next edge. All outputs take their reset values, state IDLE, no done pulse.

Optional Feature:
SEG_AUTO_REFRESH_EN
- Defined:
  - A DATA_W register last_sent holds the word of the last transmitted frame.
  - In IDLE, a frame is self-started when start=1, OR seg_txt != last_sent, OR the post-reset pending flag is set.
  - The pending flag is set by rst and cleared on the first frame start, so one frame is always sent after reset.
  - last_sent is loaded on frame acceptance.
  - Handshake timing is identical to a manual start.
- Undefined: frames start only on start. No last_sent register and no pending flag.

Decomposition:
- Package seg_p2s_pkg: state enum (IDLE, SHIFT, LATCH), counter widths derived from DATA_W and HALF_DIV via $clog2, reset constants.
- One sub-module, seg_p2s_tick: HALF_DIV phase counter emitting a phase_end strobe. It is cleared on rst and on frame acceptance.
- FSM, shift register and output registers live in seg_p2s.

Test Plan:
- Reset then idle, HALF_DIV=2: after rst, ser_clr_n=1 the next cycle; busy=0, ser_clk=0, no ser_clk edges for 100 cycles (macro undefined).
- start with seg_txt=64'hC0F9_A4B0_9992_82F8 in cycle 0: busy=1 in cycle 1; 64 ser_clk rises; bits captured on the rises reproduce the word MSB-first; ser_latch high in cycles 257-258; done in cycle 259 only.
- MSB_FIRST=0, seg_txt=64'h1: first sampled bit=1, remaining 63 bits=0.
- start pulsed at cycles 50 and 100 during a frame: ignored; exactly one done. start held high through done: second frame accepted in the done cycle, busy rises next cycle.
- rst asserted at cycle 70 mid-frame: next cycle all outputs at reset values, no done. A following start yields a complete, correct frame.
- SEG_AUTO_REFRESH_EN, start tied 0: after reset one frame is sent. Changing seg_txt 8'hFF->8'h00 in the low byte triggers one new frame. An unchanged seg_txt produces no further frames over 2000 cycles.

Source files
------------

// File: rtl/seg_p2s_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seg_p2s_pkg                                                 |
// | Purpose  : Shared types, reset constants and width helper for the      |
// |            7-segment parallel-to-serial driver.                        |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package seg_p2s_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Counter width able to hold 0..n-1; never narrower than one bit so a
  // divide of 1 or a single-bit word still yields a legal vector.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Output values while in reset. The clear line is held asserted (low).
  localparam logic c_rst_busy      = 1'b0;
  localparam logic c_rst_done      = 1'b0;
  localparam logic c_rst_ser_clk   = 1'b0;
  localparam logic c_rst_ser_dat   = 1'b0;
  localparam logic c_rst_ser_latch = 1'b0;
  localparam logic c_rst_ser_clr_n = 1'b0;

endpackage
`default_nettype wire

// File: rtl/seg_p2s_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seg_p2s_if                                                  |
// | Purpose  : Bundles the producer handshake and serial display lines.    |
// | Ports    : master - drives seg_txt/start, observes status and serial   |
// |            slave  - the driver: takes seg_txt/start, drives busy,      |
// |                     done, ser_clk, ser_dat, ser_latch, ser_clr_n       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface seg_p2s_if #(
  parameter int unsigned DATA_W = 64
);
  logic [DATA_W-1:0] seg_txt;
  logic              start;
  logic              busy;
  logic              done;
  logic              ser_clk;
  logic              ser_dat;
  logic              ser_latch;
  logic              ser_clr_n;

  modport master (
    output seg_txt, start,
    input  busy, done, ser_clk, ser_dat, ser_latch, ser_clr_n
  );

  modport slave (
    input  seg_txt, start,
    output busy, done, ser_clk, ser_dat, ser_latch, ser_clr_n
  );
endinterface
`default_nettype wire

// File: rtl/seg_p2s_tick.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seg_p2s_tick                                                |
// | Purpose  : Half-period divider. phase_end_o is high in the last cycle  |
// |            of every HALF_DIV-cycle phase.                              |
// | Ports    : clk, rst    - clock, synchronous active-high reset          |
// |            clr_i       - restart the phase (frame acceptance)          |
// |            phase_end_o - last cycle of the current phase               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module seg_p2s_tick
  import seg_p2s_pkg::*;
#(
  parameter int unsigned HALF_DIV = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr_i,
  output logic      phase_end_o
);

  localparam int unsigned      CNT_W    = cnt_w(HALF_DIV);
  localparam logic [CNT_W-1:0] c_last_q = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign phase_end_o = (cnt_q == c_last_q);

  // Reload to zero at the end of each phase; the counter never wraps by
  // overflow because c_last_q is always reachable.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (phase_end_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_p2s.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seg_p2s                                                     |
// | Purpose  : Shifts a DATA_W segment word into the display shift chain   |
// |            on a divided serial clock, then pulses the latch.           |
// | Ports    : clk, rst - clock, synchronous active-high reset             |
// |            bus      - seg_p2s_if.slave (seg_txt, start, busy, done,    |
// |                       ser_clk, ser_dat, ser_latch, ser_clr_n)          |
// | Options  : SEG_AUTO_REFRESH_EN - self-start a frame whenever seg_txt   |
// |            differs from the last word sent, and once after reset.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module seg_p2s
  import seg_p2s_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned HALF_DIV  = 2,
  parameter int unsigned MSB_FIRST = 1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  seg_p2s_if.slave    bus
);

  localparam int unsigned      BIT_W      = cnt_w(DATA_W);
  localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] sh_d;
  logic [BIT_W-1:0]  bit_q;
  logic              busy_q;
  logic              done_q;
  logic              ser_clk_q;
  logic              ser_dat_q;
  logic              ser_latch_q;
  logic              ser_clr_n_q;

  logic              w_go;
  logic              w_accept;
  logic              w_phase_end;
  logic              w_head_load;
  logic              w_head_next;

  assign w_accept = (state_q == IDLE) && w_go;

  // Bit order: the head bit is what ser_dat presents for the current bit;
  // w_head_next is the head after one advance of the shift register.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_head_load = bus.seg_txt[DATA_W-1];
      assign sh_d        = {sh_q[DATA_W-2:0], 1'b0};
      assign w_head_next = sh_q[DATA_W-2];
    end else begin : g_lsb_first
      assign w_head_load = bus.seg_txt[0];
      assign sh_d        = {1'b0, sh_q[DATA_W-1:1]};
      assign w_head_next = sh_q[1];
    end
  endgenerate

`ifdef SEG_AUTO_REFRESH_EN
  logic [DATA_W-1:0] last_sent_q;
  logic              pending_q;

  // pending_q guarantees one frame after every reset, even if the word
  // happens to match the reset value of last_sent_q.
  assign w_go = bus.start || (bus.seg_txt != last_sent_q) || pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_sent_q <= '0;
      pending_q   <= 1'b1;
    end else if (w_accept) begin
      last_sent_q <= bus.seg_txt;
      pending_q   <= 1'b0;
    end
  end
`else
  assign w_go = bus.start;
`endif

  seg_p2s_tick #(
    .HALF_DIV (HALF_DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (w_accept),
    .phase_end_o (w_phase_end)
  );

  // Sequencer. ser_dat only moves at the end of a high phase, i.e. in the
  // same edge that drops ser_clk, so it is stable across every rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      bit_q       <= '0;
      busy_q      <= c_rst_busy;
      done_q      <= c_rst_done;
      ser_clk_q   <= c_rst_ser_clk;
      ser_dat_q   <= c_rst_ser_dat;
      ser_latch_q <= c_rst_ser_latch;
      ser_clr_n_q <= c_rst_ser_clr_n;
    end else begin
      ser_clr_n_q <= 1'b1;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_go) begin
            state_q   <= SHIFT;
            sh_q      <= bus.seg_txt;
            bit_q     <= '0;
            busy_q    <= 1'b1;
            ser_clk_q <= 1'b0;
            ser_dat_q <= w_head_load;
          end
        end
        SHIFT: begin
          if (w_phase_end) begin
            if (!ser_clk_q) begin
              ser_clk_q <= 1'b1;
            end else begin
              ser_clk_q <= 1'b0;
              if (bit_q == c_last_bit) begin
                state_q     <= LATCH;
                ser_latch_q <= 1'b1;
              end else begin
                sh_q      <= sh_d;
                ser_dat_q <= w_head_next;
                bit_q     <= bit_q + BIT_W'(1);
              end
            end
          end
        end
        LATCH: begin
          if (w_phase_end) begin
            state_q     <= IDLE;
            ser_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ser_clk   = ser_clk_q;
  assign bus.ser_dat   = ser_dat_q;
  assign bus.ser_latch = ser_latch_q;
  assign bus.ser_clr_n = ser_clr_n_q;

endmodule
`default_nettype wire
